// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive controller.
// Sample width default, sample type and FSM state encoding.
package i2s_pkg;

    localparam int DATA_W_DEF = 24;

    typedef logic [DATA_W_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider for the I2S master.
// Produces bck_o plus one-cycle fall/rise strobes.
module i2s_bck_gen #(
    parameter int BCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic bck_o,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int DW = $clog2(BCK_DIV);
    localparam logic [DW-1:0] LAST = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(BCK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    // Next divider value: wrap at LAST, park at zero when stopped
    always_comb begin
        div_nxt = '0;
        if (enable && div_cnt != LAST) begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    // Divider and registered bit clock, so bck_o is glitch-free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bck_o   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bck_o   <= (div_nxt >= HALF);
        end
    end

    assign fall_evt = enable && (div_cnt == LAST);
    assign rise_evt = enable && (div_cnt == HALF);

endmodule

// File: rtl/i2s_rx_ctrl.sv
// Master-mode sequencer for the I2S receiver datapath.
// Drives bck/lrck, captures words and hands off stereo frames.
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SLOT_W  = 32,
    parameter int BCK_DIV = 2,
    parameter int OVF_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              bck_o,
    output logic              lrck_o,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic [OVF_W-1:0]  overflow_cnt
);

    localparam int BW = $clog2(SLOT_W);
    localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] CAP_BIT   = BW'(DATA_W + 1);

    i2s_state_t state;
    i2s_state_t state_nxt;

    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] left_hold;
    logic [DATA_W-1:0] right_word;
    logic              frame_done;
    logic              fall_evt;
    logic              rise_evt;
    logic              run;
    logic              slot_end;
    logic              cap_evt;

    // Divider runs while active and also on the IDLE exit cycle
    assign run      = (state != IDLE) || enable;
    assign slot_end = fall_evt && (bit_cnt == SLOT_LAST);
    assign cap_evt  = fall_evt && (bit_cnt == CAP_BIT);

    i2s_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (run),
        .bck_o    (bck_o),
        .fall_evt (fall_evt),
        .rise_evt (rise_evt)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: slots change only on a bck falling edge
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable)   state_nxt = LEFT;
            LEFT:    if (slot_end) state_nxt = RIGHT;
            RIGHT:   if (slot_end) state_nxt = enable ? LEFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        lrck_o = (state == RIGHT);
        busy   = (state != IDLE);
    end

    // Bit slot counter, advancing on each bck fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
        end else if (fall_evt) begin
            bit_cnt <= slot_end ? '0 : bit_cnt + 1'b1;
        end
    end

    // Word capture once the receiver has shifted in DATA_W bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_hold  <= '0;
            right_word <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cap_evt && state == LEFT) begin
                left_hold <= rx_data_i;
            end
            if (cap_evt && state == RIGHT) begin
                right_word <= rx_data_i;
                frame_done <= 1'b1;
            end
        end
    end

    // Output frame register with drop-on-backpressure accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_l     <= '0;
            sample_r     <= '0;
            frame_valid  <= 1'b0;
            overflow_cnt <= '0;
        end else if (frame_done) begin
            if (!frame_valid || frame_ready) begin
                sample_l    <= left_hold;
                sample_r    <= right_word;
                frame_valid <= 1'b1;
            end else if (overflow_cnt != '1) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl with a behavioural serial
// receiver model feeding rx_data_i from bck/lrck.
module tb_i2s_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_ready;
    logic [23:0] rx_data;
    logic        bck_o;
    logic        lrck_o;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        frame_valid;
    logic        busy;
    logic [7:0]  overflow_cnt;

    int checks = 0;
    int errors = 0;

    // receiver model state
    logic [23:0] l_base = 24'h0;
    logic [23:0] r_base = 24'h0;
    logic [23:0] cur_word;
    logic [23:0] m_sh = 24'h0;
    int          m_bit = 0;
    int          m_fidx = 0;
    logic        p_bck = 1'b0;
    logic        p_lrck = 1'b0;

    i2s_rx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_data_i    (rx_data),
        .bck_o        (bck_o),
        .lrck_o       (lrck_o),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    // frame n carries base + n on each channel
    assign cur_word = lrck_o ? (r_base + 24'(m_fidx))
                             : (l_base + 24'(m_fidx));
    assign rx_data  = m_sh;

    // Serial receiver: MSB at slot bit 1, shift on bck rise, hold after DATA_W bits
    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            m_bit  <= 0;
            m_fidx <= 0;
            m_sh   <= 24'h0;
        end else begin
            if (lrck_o != p_lrck) begin
                m_bit <= 0;
                if (!lrck_o) m_fidx <= m_fidx + 1;
            end else if (!bck_o && p_bck) begin
                m_bit <= m_bit + 1;
            end
            if (bck_o && !p_bck) begin
                if (m_bit == 0)
                    m_sh <= 24'h0;
                else if (m_bit <= 24)
                    m_sh <= {m_sh[22:0], cur_word[24 - m_bit]};
            end
        end
        p_bck  <= bck_o;
        p_lrck <= lrck_o;
    end

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bck_o !== 1'b0 || lrck_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk: bck=%b lrck=%b want 0 0", bck_o, lrck_o);
        end
        checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b want 0 0", frame_valid, busy);
        end
        checks++;
        if (sample_l !== 24'h0 || sample_r !== 24'h0) begin
            errors++;
            $display("FAIL reset_samples: l=%h r=%h want 0 0", sample_l, sample_r);
        end
        checks++;
        if (overflow_cnt !== 8'h0) begin
            errors++;
            $display("FAIL reset_ovf: got %0d want 0", overflow_cnt);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bck_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b bck=%b want 0 0", busy, bck_o);
        end
    endtask

    task automatic test_timing();
        int n;
        int hi;
        int same;
        logic prev;
        do_reset();
        enable = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1 || bck_o !== 1'b1 || lrck_o !== 1'b0) begin
            errors++;
            $display("FAIL start: busy=%b bck=%b lrck=%b want 1 1 0", busy, bck_o, lrck_o);
        end
        n = 0;
        while (lrck_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (lrck_o === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL right_len: got %0d clk want 64", n);
        end
        n = 0;
        hi = 0;
        same = 0;
        prev = 1'b1;
        while (lrck_o === 1'b0 && n < 200) begin
            if (bck_o === prev) same++;
            if (bck_o === 1'b1) hi++;
            prev = bck_o;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL left_len: got %0d clk want 64", n);
        end
        checks++;
        if (hi != 32 || same != 0) begin
            errors++;
            $display("FAIL bck_duty: high=%0d repeats=%0d want 32 0", hi, same);
        end
    endtask

    task automatic test_frame();
        int n;
        do_reset();
        l_base      = 24'hA5C3F1;
        r_base      = 24'h123456;
        frame_ready = 1'b1;
        enable      = 1'b1;
        n = 0;
        while (lrck_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (frame_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 53) begin
            errors++;
            $display("FAIL valid_latency: got %0d clk after lrck rise want 53", n);
        end
        checks++;
        if (sample_l !== 24'hA5C3F1 || sample_r !== 24'h123456) begin
            errors++;
            $display("FAIL frame_data: l=%h r=%h want a5c3f1 123456", sample_l, sample_r);
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: got %b want 0", frame_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int moved;
        do_reset();
        l_base      = 24'h100001;
        r_base      = 24'h200002;
        frame_ready = 1'b0;
        enable      = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sample_l !== 24'h100001 || sample_r !== 24'h200002) begin
            errors++;
            $display("FAIL bp_first: l=%h r=%h want 100001 200002", sample_l, sample_r);
        end
        n = 0;
        moved = 0;
        while (overflow_cnt !== 8'd2 && n < 400) begin
            @(negedge clk);
            if (sample_l !== 24'h100001 || sample_r !== 24'h200002 ||
                frame_valid !== 1'b1) moved++;
            n++;
        end
        checks++;
        if (overflow_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_ovf: got %0d want 2", overflow_cnt);
        end
        checks++;
        if (moved != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d cycles changed want 0", moved);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: valid=%b want 0", frame_valid);
        end
        n = 0;
        while (frame_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sample_l !== 24'h100004 || sample_r !== 24'h200005) begin
            errors++;
            $display("FAIL bp_next: l=%h r=%h want 100004 200005", sample_l, sample_r);
        end
        checks++;
        if (overflow_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_ovf_after: got %0d want 2", overflow_cnt);
        end
    endtask

    task automatic test_stop();
        int n;
        logic seen;
        logic [23:0] got_l;
        logic [23:0] got_r;
        do_reset();
        l_base      = 24'h0ABCDE;
        r_base      = 24'h0FEDCB;
        frame_ready = 1'b1;
        enable      = 1'b1;
        n = 0;
        while (!(busy === 1'b1 && lrck_o === 1'b0 && m_bit == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        seen   = 1'b0;
        got_l  = 24'h0;
        got_r  = 24'h0;
        n = 0;
        while (lrck_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (frame_valid === 1'b1 && !seen) begin
                seen  = 1'b1;
                got_l = sample_l;
                got_r = sample_r;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL stop_right_len: got %0d clk want 64", n);
        end
        checks++;
        if (!seen || got_l !== 24'h0ABCDE || got_r !== 24'h0FEDCB) begin
            errors++;
            $display("FAIL stop_frame: seen=%b l=%h r=%h want 1 0abcde 0fedcb", seen, got_l, got_r);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bck_o !== 1'b0 || lrck_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: busy=%b bck=%b lrck=%b want 0 0 0", busy, bck_o, lrck_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        l_base      = 24'h111111;
        r_base      = 24'h222222;
        frame_ready = 1'b0;
        enable      = 1'b1;
        n = 0;
        while (!(m_fidx == 1 && lrck_o === 1'b1 && m_bit == 10) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: valid=%b want 1", frame_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bck_o !== 1'b0 || lrck_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_clk: bck=%b lrck=%b busy=%b want 0 0 0", bck_o, lrck_o, busy);
        end
        checks++;
        if (frame_valid !== 1'b0 || sample_l !== 24'h0 || sample_r !== 24'h0) begin
            errors++;
            $display("FAIL mid_async_frame: valid=%b l=%h r=%h want 0 0 0", frame_valid, sample_l, sample_r);
        end
        @(negedge clk);
        @(negedge clk);
        reset       = 1'b0;
        frame_ready = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lrck_o !== 1'b0 || bck_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: lrck=%b bck=%b want 0 1", lrck_o, bck_o);
        end
        n = 0;
        while (frame_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 116) begin
            errors++;
            $display("FAIL mid_latency: got %0d clk want 116", n);
        end
        checks++;
        if (sample_l !== 24'h111111 || sample_r !== 24'h222222) begin
            errors++;
            $display("FAIL mid_frame: l=%h r=%h want 111111 222222", sample_l, sample_r);
        end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        l_base      = 24'h0A0A0A;
        r_base      = 24'h0B0B0B;
        frame_ready = 1'b0;
        enable      = 1'b1;
        n = 0;
        while (m_fidx != 11 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (overflow_cnt !== 8'd10) begin
            errors++;
            $display("FAIL sat_partial: got %0d want 10", overflow_cnt);
        end
        n = 0;
        while (m_fidx != 301 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (overflow_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 255", overflow_cnt);
        end
        checks++;
        if (frame_valid !== 1'b1 || sample_l !== 24'h0A0A0A || sample_r !== 24'h0B0B0B) begin
            errors++;
            $display("FAIL sat_frame: valid=%b l=%h r=%h want 1 0a0a0a 0b0b0b", frame_valid, sample_l, sample_r);
        end
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_ready = 1'b0;
        test_reset();
        test_timing();
        test_frame();
        test_backpressure();
        test_stop();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_ctrl.md
Name: i2s_rx_ctrl

Overview:
- Master-mode sequencer for the I2S receiver datapath (i2s_rcvr).
- Generates bck and lrck from the system clock, counts bit slots, and latches the receiver's parallel word at the end of each channel.
- Packs left/right words into a stereo frame with a valid/ready handshake toward the downstream sample buffer.
- Counts frames dropped on backpressure.

Parameters:
- DATA_W, 24: sample width; matches receiver data_out.
- SLOT_W, 32: bck periods per channel half-frame; must be ≥ DATA_W+2.
- BCK_DIV, 2: clk cycles per bck period; even, ≥2.
- OVF_W, 8: width of the overflow counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; 1 = run, 0 = stop at the next frame boundary.
- rx_data_i  input  DATA_W  parallel word from receiver data_out.
- bck_o  output  1  I2S bit clock to the receiver.
- lrck_o  output  1  word select: 0 = left, 1 = right.
- sample_l  output  DATA_W  left word of the presented frame.
- sample_r  output  DATA_W  right word of the presented frame.
- frame_valid  output  1  stereo frame available.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  state ≠ IDLE.
- overflow_cnt  output  OVF_W  saturating count of dropped frames.

Behaviour:
- Reset (async, immediate):
  - All outputs 0: bck_o=0, lrck_o=0, frame_valid=0, sample_l/r=0, overflow_cnt=0, busy=0.
  - div_cnt=0, bit_cnt=0, state=IDLE.
  - Reset mid-frame discards the partial frame and any pending unaccepted frame.
- Divider:
  - div_cnt counts 0..BCK_DIV-1 while state≠IDLE.
  - bck_o=0 for div_cnt < BCK_DIV/2, else 1.
  - fall_evt is the clk cycle where div_cnt wraps to 0; rise_evt is where div_cnt == BCK_DIV/2.
- Bit counter:
  - bit_cnt 0..SLOT_W-1, advances on fall_evt.
  - On wrap, lrck_o toggles in the same cycle, i.e. lrck changes on a bck falling edge.
  - The receiver's one-bit I2S delay places the MSB at bit_cnt=1.
- States:
  - IDLE: bck_o=0, lrck_o=0. Goes to LEFT when enable=1: next cycle div_cnt=1, bit_cnt=0, lrck_o=0.
  - LEFT: lrck_o=0. On fall_evt with bit_cnt==DATA_W+1, latch rx_data_i into left_hold. On slot wrap → RIGHT (lrck_o=1).
  - RIGHT: lrck_o=1. On fall_evt with bit_cnt==DATA_W+1, latch rx_data_i as right_word and raise frame_done for one cycle. On slot wrap → LEFT if enable=1, else → IDLE with bck_o=0, lrck_o=0.
  - enable falling mid-frame never truncates; the current right slot always completes.
- Output register:
  - On frame_done, the frame loads if frame_valid=0 or frame_ready=1 in the same cycle: {sample_l, sample_r} ← {left_hold, right_word}, frame_valid=1.
  - Otherwise the frame is dropped, the held frame is unchanged, and overflow_cnt increments, saturating at 2^OVF_W-1.
  - frame_valid clears on frame_ready with no simultaneous load.
  - sample_l/r are stable while frame_valid=1 and frame_ready=0.
- Timing: latency from right-word latch to frame_valid is 1 clk.

Decomposition:
- Package i2s_pkg:
  - DATA_W default constant.
  - typedef logic [DATA_W-1:0] sample_t.
  - typedef enum {IDLE, LEFT, RIGHT} i2s_state_t.
- Sub-module i2s_bck_gen: divider plus bck_o, fall_evt, rise_evt; enable input, same clk/reset.
- FSM, bit counter, capture, and output handshake stay in i2s_rx_ctrl.

Test Plan:
Default parameters throughout (BCK_DIV=2, SLOT_W=32): one frame = 64 bck = 128 clk.
1. Reset, then enable=1 → first bck_o rise 1 clk after leaving IDLE; lrck_o toggles every 64 clk; bck_o period 2 clk, 50% duty.
2. Serial left=24'hA5C3F1, right=24'h123456 driven into the receiver, frame_ready=1 → frame_valid pulses 1 clk with sample_l=24'hA5C3F1, sample_r=24'h123456, 1 clk after the right latch.
3. frame_ready=0 for 3 frames → first frame held stable; overflow_cnt=2; after ready=1, the next delivered frame is frame 4.
4. enable→0 at bit_cnt=5 of LEFT → left and right slots complete, frame delivered, then IDLE with bck_o=0, lrck_o=0, busy=0.
5. reset asserted at bit_cnt=10 of RIGHT with frame_valid=1 → all outputs 0 immediately; after release with enable=1, a clean frame starts at LEFT bit_cnt=0.
6. Force overflow_cnt to 255 via 300 dropped frames → holds 255, no wrap.
